// File: rtl/ac_unit.sv
// Parametrised accumulator with status flags and a multi-cycle shift-add multiplier.
// Optional signed saturation for ADD/SUB/INC/DEC is enabled by defining AC_SATURATE_EN.
module ac_unit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             re,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] out1,
  output logic             zf,
  output logic             nf,
  output logic             cf,
  output logic             vf,
  output logic             busy,
  output logic             done
);

  localparam int unsigned Msb = WIDTH - 1;

  localparam logic [3:0] OpLoad = 4'd1;
  localparam logic [3:0] OpAdd  = 4'd2;
  localparam logic [3:0] OpSub  = 4'd3;
  localparam logic [3:0] OpAnd  = 4'd4;
  localparam logic [3:0] OpOr   = 4'd5;
  localparam logic [3:0] OpXor  = 4'd6;
  localparam logic [3:0] OpNot  = 4'd7;
  localparam logic [3:0] OpShl  = 4'd8;
  localparam logic [3:0] OpShr  = 4'd9;
  localparam logic [3:0] OpInc  = 4'd10;
  localparam logic [3:0] OpDec  = 4'd11;
  localparam logic [3:0] OpClr  = 4'd12;
  localparam logic [3:0] OpMul  = 4'd13;

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e               state_q;
  logic [WIDTH-1:0]     ac_q;
  logic                 zf_q, nf_q, cf_q, vf_q;
  logic                 busy_q, done_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic [CNT_W-1:0]     cnt_q;

  // Shared adder/subtractor used by ADD, SUB, INC and DEC.
  logic             is_inc_dec;
  logic             is_sub;
  logic [WIDTH-1:0] arith_b;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic [WIDTH-1:0] arith_raw;
  logic [WIDTH-1:0] arith_res;
  logic             arith_c;
  logic             arith_v;

  always_comb begin
    is_inc_dec = (op == OpInc) || (op == OpDec);
    is_sub     = (op == OpSub) || (op == OpDec);
    arith_b    = is_inc_dec ? WIDTH'(1) : in1;
    sum_w      = {1'b0, ac_q} + {1'b0, arith_b};
    diff_w     = {1'b0, ac_q} - {1'b0, arith_b};
    arith_raw  = is_sub ? diff_w[WIDTH-1:0] : sum_w[WIDTH-1:0];
    arith_c    = is_sub ? diff_w[WIDTH] : sum_w[WIDTH];
    if (is_sub) begin
      arith_v = (ac_q[Msb] != arith_b[Msb]) && (arith_raw[Msb] != ac_q[Msb]);
    end else begin
      arith_v = (ac_q[Msb] == arith_b[Msb]) && (arith_raw[Msb] != ac_q[Msb]);
    end
`ifdef AC_SATURATE_EN
    // Overflow direction always follows the sign of the accumulator operand.
    if (arith_v) begin
      arith_res = ac_q[Msb] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      arith_res = arith_raw;
    end
`else
    arith_res = arith_raw;
`endif
  end

  // Single-cycle result and flag selection.
  logic             alu_upd;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;

  always_comb begin
    alu_upd = 1'b1;
    alu_res = ac_q;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OpLoad: alu_res = in1;
      OpAdd, OpSub, OpInc, OpDec: begin
        alu_res = arith_res;
        alu_c   = arith_c;
        alu_v   = arith_v;
      end
      OpAnd: alu_res = ac_q & in1;
      OpOr:  alu_res = ac_q | in1;
      OpXor: alu_res = ac_q ^ in1;
      OpNot: alu_res = ~ac_q;
      OpShl: begin
        alu_res = {ac_q[WIDTH-2:0], 1'b0};
        alu_c   = ac_q[Msb];
      end
      OpShr: begin
        alu_res = {1'b0, ac_q[WIDTH-1:1]};
        alu_c   = ac_q[0];
      end
      OpClr: alu_res = '0;
      default: alu_upd = 1'b0;
    endcase
  end

  logic [2*WIDTH-1:0] prod_step;
  logic               mul_last;

  always_comb begin
    prod_step = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
    mul_last  = (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q  <= StIdle;
      ac_q     <= '0;
      zf_q     <= 1'b0;
      nf_q     <= 1'b0;
      cf_q     <= 1'b0;
      vf_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (re) begin
            if (op == OpMul) begin
              mcand_q  <= {{WIDTH{1'b0}}, ac_q};
              mplier_q <= in1;
              prod_q   <= '0;
              cnt_q    <= '0;
              busy_q   <= 1'b1;
              state_q  <= StMul;
            end else if (alu_upd) begin
              ac_q <= alu_res;
              zf_q <= (alu_res == '0);
              nf_q <= alu_res[Msb];
              cf_q <= alu_c;
              vf_q <= alu_v;
            end
          end
        end
        StMul: begin
          prod_q   <= prod_step;
          mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
          cnt_q    <= cnt_q + CNT_W'(1);
          if (mul_last) begin
            ac_q    <= prod_step[WIDTH-1:0];
            zf_q    <= (prod_step[WIDTH-1:0] == '0);
            nf_q    <= prod_step[Msb];
            cf_q    <= |prod_step[2*WIDTH-1:WIDTH];
            vf_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out1 = ac_q;
  assign zf   = zf_q;
  assign nf   = nf_q;
  assign cf   = cf_q;
  assign vf   = vf_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_ac_unit.sv
// Self-checking bench for ac_unit: directed scenarios plus random traffic against an
// arithmetic reference model (honours AC_SATURATE_EN when defined).
module tb_ac_unit;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          clear;
  logic          re;
  logic [3:0]    op;
  logic [W-1:0]  in1;
  logic [W-1:0]  out1;
  logic          zf, nf, cf, vf, busy, done;

  always #5 clk = ~clk;

  ac_unit #(.WIDTH(W), .CNT_W(5)) dut (
    .clk   (clk),
    .clear (clear),
    .re    (re),
    .op    (op),
    .in1   (in1),
    .out1  (out1),
    .zf    (zf),
    .nf    (nf),
    .cf    (cf),
    .vf    (vf),
    .busy  (busy),
    .done  (done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [W-1:0] m_ac;
  logic         m_z, m_n, m_c, m_v;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_ac = '0;
    m_z  = 1'b0;
    m_n  = 1'b0;
    m_c  = 1'b0;
    m_v  = 1'b0;
  endtask

  task automatic model_set(input longint r, input logic c, input logic v);
    m_ac = W'(r);
    m_z  = (r == 0);
    m_n  = (r >= 32768);
    m_c  = c;
    m_v  = v;
  endtask

  // Single-cycle opcode semantics expressed with plain integer arithmetic.
  task automatic model_apply(input logic [3:0] o, input logic [W-1:0] b);
    longint a, bb, r, ss;
    int     sa, sb;
    logic   c, v, arith;
    a = longint'(m_ac);
    bb = longint'(b);
    sa = $signed(m_ac);
    sb = $signed(b);
    c = 1'b0;
    v = 1'b0;
    arith = 1'b0;
    r = a;
    ss = 0;
    if (o == 4'd10 || o == 4'd11) begin
      bb = 1;
      sb = 1;
    end
    case (o)
      4'd1: r = bb;
      4'd2, 4'd10: begin
        r = (a + bb) % 65536;
        c = (a + bb) >= 65536;
        ss = longint'(sa) + longint'(sb);
        arith = 1'b1;
      end
      4'd3, 4'd11: begin
        r = (a - bb + 65536) % 65536;
        c = a < bb;
        ss = longint'(sa) - longint'(sb);
        arith = 1'b1;
      end
      4'd4: r = longint'(m_ac & b);
      4'd5: r = longint'(m_ac | b);
      4'd6: r = longint'(m_ac ^ b);
      4'd7: r = 65535 - a;
      4'd8: begin
        r = (a * 2) % 65536;
        c = a >= 32768;
      end
      4'd9: begin
        r = a / 2;
        c = (a % 2) == 1;
      end
      4'd12: r = 0;
      default: return;
    endcase
    if (arith) begin
      v = (ss > 32767) || (ss < -32768);
`ifdef AC_SATURATE_EN
      if (v) r = (ss > 0) ? 32767 : 32768;
`endif
    end
    model_set(r, c, v);
  endtask

  task automatic check_state(input string tag, input logic exp_busy, input logic exp_done);
    check_eq({tag, " out1"}, 32'(out1), 32'(m_ac));
    check_eq({tag, " flags zncv"}, {28'd0, zf, nf, cf, vf}, {28'd0, m_z, m_n, m_c, m_v});
    check_eq({tag, " busy/done"}, {30'd0, busy, done}, {30'd0, exp_busy, exp_done});
  endtask

  task automatic do_op(input string tag, input logic [3:0] o, input logic [W-1:0] b);
    clear = 1'b0;
    re    = 1'b1;
    op    = o;
    in1   = b;
    tick();
    model_apply(o, b);
    check_state(tag, 1'b0, 1'b0);
  endtask

  // Multiply m_ac by b; during busy, re stays high with hold_op (or random ops if rand_hold).
  task automatic run_mul(input string tag, input logic [W-1:0] b, input logic [3:0] hold_op,
                         input logic rand_hold);
    longint prod;
    int     pulses;
    prod = longint'(m_ac) * longint'(b);
    pulses = 0;
    clear = 1'b0;
    re    = 1'b1;
    op    = 4'd13;
    in1   = b;
    tick();
    check_state({tag, " accept"}, 1'b1, 1'b0);
    for (int i = 1; i <= W; i++) begin
      re  = 1'b1;
      op  = rand_hold ? 4'($urandom_range(0, 15)) : hold_op;
      in1 = W'($urandom);
      tick();
      if (done) pulses++;
      if (i < W) begin
        check_state({tag, " busy"}, 1'b1, 1'b0);
      end else begin
        model_set(prod % 65536, (prod / 65536) != 0, 1'b0);
        check_state({tag, " done"}, 1'b0, 1'b1);
      end
    end
    check_eq({tag, " done pulses"}, 32'(pulses), 32'd1);
  endtask

  initial begin
    clear = 1'b1;
    re    = 1'b1;
    op    = 4'd1;
    in1   = 16'h1234;
    model_reset();
    tick();
    check_state("reset0", 1'b0, 1'b0);
    tick();
    check_state("reset1", 1'b0, 1'b0);
    check_eq("reset out1", 32'(out1), 32'h0);

    do_op("load", 4'd1, 16'h1234);
    check_eq("load const", 32'(out1), 32'h1234);

    // hold with re=0
    re = 1'b0;
    op = 4'd12;
    tick();
    check_state("hold re0", 1'b0, 1'b0);

    do_op("load7fff", 4'd1, 16'h7FFF);
    do_op("add ovf", 4'd2, 16'h0001);
`ifdef AC_SATURATE_EN
    check_eq("add ovf const", {16'd0, out1}, 32'h7FFF);
`else
    check_eq("add ovf const", {16'd0, out1}, 32'h8000);
`endif
    check_eq("add ovf vf", 32'(vf), 32'd1);

    do_op("load0", 4'd1, 16'h0000);
    do_op("dec wrap", 4'd11, 16'h5555);
    check_eq("dec const", {16'd0, out1}, 32'hFFFF);
    check_eq("dec cf", 32'(cf), 32'd1);
    do_op("inc wrap", 4'd10, 16'h0000);
    check_eq("inc const", {28'd0, out1[3:0], zf, cf, 2'b00}, 32'h0000_000C);

    do_op("load8001", 4'd1, 16'h8001);
    do_op("shl", 4'd8, 16'h0000);
    check_eq("shl const", {16'd0, out1}, 32'h0002);
    do_op("shr", 4'd9, 16'h0000);
    check_eq("shr const", {15'd0, out1, cf}, 32'h0002);

    do_op("load0300", 4'd1, 16'h0300);
    run_mul("mul1", 16'h0200, 4'd2, 1'b0);
    check_eq("mul1 const", {15'd0, out1, zf}, 32'h0001);
    check_eq("mul1 cf", 32'(cf), 32'd1);
    do_op("load5", 4'd1, 16'h0005);
    run_mul("mul2", 16'h0003, 4'd2, 1'b0);
    check_eq("mul2 const", {15'd0, out1, cf}, 32'h001E);
    // operation presented while done is high is accepted
    do_op("after done", 4'd2, 16'h0010);

    // clear aborts a multiply
    do_op("load abort", 4'd1, 16'h1111);
    re  = 1'b1;
    op  = 4'd13;
    in1 = 16'h0007;
    tick();
    check_state("abort accept", 1'b1, 1'b0);
    re = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_state("abort busy", 1'b1, 1'b0);
    clear = 1'b1;
    tick();
    model_reset();
    check_state("abort clear", 1'b0, 1'b0);
    clear = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      tick();
      check_eq("abort no done", {31'd0, done}, 32'd0);
    end
    do_op("loadABCD", 4'd1, 16'hABCD);
    check_eq("loadABCD const", {16'd0, out1}, 32'hABCD);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      int sel;
      sel = $urandom_range(0, 99);
      if (sel < 3) begin
        clear = 1'b1;
        re    = $urandom_range(0, 1);
        op    = 4'($urandom_range(0, 15));
        in1   = W'($urandom);
        tick();
        model_reset();
        check_state("rand clear", 1'b0, 1'b0);
        clear = 1'b0;
      end else if (sel < 10) begin
        run_mul("rand mul", W'($urandom), 4'd0, 1'b1);
      end else begin
        logic [3:0]   o;
        logic [W-1:0] b;
        logic         en;
        o  = 4'($urandom_range(0, 15));
        if (o == 4'd13) o = 4'd14;
        b  = W'($urandom);
        en = ($urandom_range(0, 9) < 8);
        clear = 1'b0;
        re    = en;
        op    = o;
        in1   = b;
        tick();
        if (en) model_apply(o, b);
        check_state("rand op", 1'b0, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
